// File: rtl/fir_coef_loader_if.sv
// ============================================================================
// fir_coef_loader_if
//   Coefficient stream and resampler write-bus bundle for fir_coef_loader.
//   Rev 1.0
// ============================================================================
`default_nettype none

interface fir_coef_loader_if #(
  parameter int COEF_WIDTH  = 16,
  parameter int COEF_AWIDTH = 8
);
  logic                   start_i;
  logic [COEF_WIDTH-1:0]  s_data_i;
  logic                   s_val_i;
  logic                   s_last_i;
  logic                   s_rdy_o;
  logic                   coef_we_o;
  logic [COEF_AWIDTH-1:0] coef_addr_o;
  logic [COEF_WIDTH-1:0]  coef_data_o;
  logic                   busy_o;
  logic                   done_o;
  logic [1:0]             err_o;

  modport master (
    output start_i, s_data_i, s_val_i, s_last_i,
    input  s_rdy_o, coef_we_o, coef_addr_o, coef_data_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, s_data_i, s_val_i, s_last_i,
    output s_rdy_o, coef_we_o, coef_addr_o, coef_data_o, busy_o, done_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/fir_coef_loader.sv
// ============================================================================
// fir_coef_loader
//   Framed coefficient-stream loader with optional symmetric mirroring.
//   Rev 1.0
// ============================================================================
`default_nettype none

module fir_coef_loader #(
  parameter int FILTER_ORDER = 256,
  parameter int COEF_WIDTH   = 16,
  parameter bit SYMMETRIC    = 1'b0,
  parameter int COEF_AWIDTH  = $clog2(FILTER_ORDER)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fir_coef_loader_if.slave     bus
);

  localparam int                     N        = SYMMETRIC ? FILTER_ORDER / 2 : FILTER_ORDER;
  localparam logic [COEF_AWIDTH-1:0] K_LAST   = COEF_AWIDTH'(N - 1);
  localparam logic [COEF_AWIDTH-1:0] ADDR_TOP = COEF_AWIDTH'(FILTER_ORDER - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MIRROR = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FIN    = 3'd4
  } state_t;

  state_t                 r_state;
  logic [COEF_AWIDTH-1:0] r_k;
  logic                   r_rdy;
  logic                   r_we;
  logic [COEF_AWIDTH-1:0] r_addr;
  logic [COEF_WIDTH-1:0]  r_data;
  logic                   r_busy;
  logic                   r_done;
  logic [1:0]             r_err;
  logic                   r_last;
  logic                   r_fin_wait;

  logic w_xfer;
  logic w_eval;
  logic w_eval_last;

  assign w_xfer      = bus.s_val_i & r_rdy;
  // The end condition is judged once per word: on its transfer, or on its mirror write.
  assign w_eval      = ((r_state == ST_LOAD) && w_xfer && !SYMMETRIC) || (r_state == ST_MIRROR);
  assign w_eval_last = (r_state == ST_MIRROR) ? r_last : bus.s_last_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_rdy      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= '0;
      r_last     <= 1'b0;
      r_fin_wait <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_state <= ST_LOAD;
            r_k     <= '0;
            r_err   <= '0;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_we   <= 1'b1;
            r_addr <= r_k;
            r_data <= bus.s_data_i;
            r_last <= bus.s_last_i;
            if (SYMMETRIC) begin
              r_state <= ST_MIRROR;
              r_rdy   <= 1'b0;
            end
          end
        end
        ST_MIRROR: begin
          r_we   <= 1'b1;
          r_addr <= ADDR_TOP - r_k;
        end
        ST_DRAIN: begin
          if (w_xfer && bus.s_last_i) begin
            r_state    <= ST_FIN;
            r_rdy      <= 1'b0;
            r_done     <= 1'b1;
            r_fin_wait <= 1'b0;
          end
        end
        ST_FIN: begin
          // After a load, FIN holds one extra cycle so done trails the final write strobe.
          if (r_fin_wait) begin
            r_fin_wait <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_eval) begin
        if (r_k == K_LAST) begin
          if (w_eval_last) begin
            r_state    <= ST_FIN;
            r_rdy      <= 1'b0;
            r_fin_wait <= 1'b1;
          end else begin
            r_err[1] <= 1'b1;
            r_state  <= ST_DRAIN;
            r_rdy    <= 1'b1;
          end
        end else if (w_eval_last) begin
          r_err[0]   <= 1'b1;
          r_state    <= ST_FIN;
          r_rdy      <= 1'b0;
          r_fin_wait <= 1'b1;
        end else begin
          r_k     <= r_k + 1'b1;
          r_state <= ST_LOAD;
          r_rdy   <= 1'b1;
        end
      end
    end
  end

  assign bus.s_rdy_o     = r_rdy;
  assign bus.coef_we_o   = r_we;
  assign bus.coef_addr_o = r_addr;
  assign bus.coef_data_o = r_data;
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
// ============================================================================
// tb_fir_coef_loader
//   Randomized self-checking bench: plain and symmetric loaders, FILTER_ORDER 8.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_fir_coef_loader;
  localparam int FO = 8;
  localparam int CW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fir_coef_loader_if #(.COEF_WIDTH(CW), .COEF_AWIDTH(AW)) bus0 ();
  fir_coef_loader_if #(.COEF_WIDTH(CW), .COEF_AWIDTH(AW)) bus1 ();

  logic [1:0]    start_d = '0;
  logic [1:0]    val_d   = '0;
  logic [1:0]    last_d  = '0;
  logic [CW-1:0] data_d [2];

  assign bus0.start_i  = start_d[0];
  assign bus0.s_val_i  = val_d[0];
  assign bus0.s_last_i = last_d[0];
  assign bus0.s_data_i = data_d[0];
  assign bus1.start_i  = start_d[1];
  assign bus1.s_val_i  = val_d[1];
  assign bus1.s_last_i = last_d[1];
  assign bus1.s_data_i = data_d[1];

  fir_coef_loader #(.FILTER_ORDER(FO), .COEF_WIDTH(CW), .SYMMETRIC(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0));
  fir_coef_loader #(.FILTER_ORDER(FO), .COEF_WIDTH(CW), .SYMMETRIC(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1));

  logic [1:0] rdy_v, busy_v, done_v, we_v;
  logic [1:0] err_v [2];
  assign rdy_v    = {bus1.s_rdy_o, bus0.s_rdy_o};
  assign busy_v   = {bus1.busy_o, bus0.busy_o};
  assign done_v   = {bus1.done_o, bus0.done_o};
  assign we_v     = {bus1.coef_we_o, bus0.coef_we_o};
  assign err_v[0] = bus0.err_o;
  assign err_v[1] = bus1.err_o;

  typedef struct {int sel; int addr; int data; int cyc;} wr_t;
  typedef struct {int sel; int cyc;} ev_t;
  wr_t wq[$];
  ev_t dq[$];
  ev_t bq[$];
  int  xq[$];
  int  words[$];

  logic [CW-1:0] mem_ref [2][FO];
  logic [CW-1:0] mem_dut [2][FO];

  int checks = 0;
  int errors = 0;

  logic [1:0] busy_prev = '0;
  always @(negedge clk) begin
    if (bus0.coef_we_o) begin
      wq.push_back('{0, int'(bus0.coef_addr_o), int'(bus0.coef_data_o), cyc});
      mem_dut[0][bus0.coef_addr_o] = bus0.coef_data_o;
    end
    if (bus1.coef_we_o) begin
      wq.push_back('{1, int'(bus1.coef_addr_o), int'(bus1.coef_data_o), cyc});
      mem_dut[1][bus1.coef_addr_o] = bus1.coef_data_o;
    end
    if (bus0.done_o) dq.push_back('{0, cyc});
    if (bus1.done_o) dq.push_back('{1, cyc});
    if (busy_prev[0] && !bus0.busy_o) bq.push_back('{0, cyc});
    if (busy_prev[1] && !bus1.busy_o) bq.push_back('{1, cyc});
    busy_prev = busy_v;
  end

  // Drive one frame of len words into loader sel and check it against the frame rules.
  task automatic run_frame(input int sel, input int len, input int base, input int gap_pct,
                           input bit poke_start, input string name);
    int  n;
    int  i, guard, c, nw, exp_done, exp_err, dcnt, dcyc, bcnt, bcyc;
    bit  v, r;
    wr_t exp_w[$];
    wr_t got[$];
    n = (sel == 1) ? FO / 2 : FO;
    wq.delete(); dq.delete(); bq.delete(); xq.delete(); words.delete();
    for (int j = 0; j < len; j++)
      words.push_back((base >= 0) ? (base + j) : int'($urandom_range(16'hFFFF)));

    @(negedge clk); start_d[sel] = 1'b1;
    @(negedge clk); start_d[sel] = 1'b0;
    checks++;
    if (err_v[sel] !== 2'b00 || busy_v[sel] !== 1'b1 || rdy_v[sel] !== 1'b1) begin
      errors++;
      $display("FAIL %s start: err=%b busy=%b rdy=%b, required err=00 busy=1 rdy=1",
               name, err_v[sel], busy_v[sel], rdy_v[sel]);
    end

    i = 0; guard = 0;
    while (i < len && guard < 400) begin
      r = rdy_v[sel];
      c = cyc;
      v = ($urandom_range(99) >= gap_pct);
      val_d[sel]  = v;
      data_d[sel] = CW'(words[i]);
      last_d[sel] = (i == len - 1);
      if (poke_start && i == 2) start_d[sel] = 1'b1;
      @(negedge clk);
      start_d[sel] = 1'b0;
      if (v && r) begin
        xq.push_back(c);
        i++;
      end
      guard++;
    end
    val_d[sel] = 1'b0; last_d[sel] = 1'b0;
    if (i < len) begin
      checks++; errors++;
      $display("FAIL %s xfer_timeout: transferred %0d words, required %0d", name, i, len);
      return;
    end
    guard = 0;
    while (dq.size() == 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);

    // Reference: the first min(len,N) words land at k (and FO-1-k when mirrored).
    nw = (len < n) ? len : n;
    for (int j = 0; j < nw; j++) begin
      exp_w.push_back('{sel, j, words[j], xq[j] + 1});
      mem_ref[sel][j] = CW'(words[j]);
      if (sel == 1) begin
        exp_w.push_back('{sel, FO - 1 - j, words[j], xq[j] + 2});
        mem_ref[sel][FO - 1 - j] = CW'(words[j]);
      end
    end
    exp_done = (len > n) ? xq[len - 1] + 1 : exp_w[exp_w.size() - 1].cyc + 1;
    exp_err  = (len < n) ? 1 : (len > n) ? 2 : 0;

    foreach (wq[j]) if (wq[j].sel == sel) got.push_back(wq[j]);
    checks++;
    if (got.size() !== exp_w.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d, required %0d", name, got.size(), exp_w.size());
    end
    for (int j = 0; j < exp_w.size() && j < got.size(); j++) begin
      checks++;
      if (got[j].addr !== exp_w[j].addr || got[j].data !== exp_w[j].data ||
          got[j].cyc !== exp_w[j].cyc) begin
        errors++;
        $display("FAIL %s write[%0d]: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                 name, j, got[j].addr, got[j].data, got[j].cyc,
                 exp_w[j].addr, exp_w[j].data, exp_w[j].cyc);
      end
    end

    dcnt = 0; dcyc = -1; bcnt = 0; bcyc = -1;
    foreach (dq[j]) if (dq[j].sel == sel) begin dcnt++; dcyc = dq[j].cyc; end
    foreach (bq[j]) if (bq[j].sel == sel) begin bcnt++; bcyc = bq[j].cyc; end
    checks++;
    if (dcnt !== 1 || dcyc !== exp_done) begin
      errors++;
      $display("FAIL %s done: pulses=%0d cyc=%0d, required pulses=1 cyc=%0d",
               name, dcnt, dcyc, exp_done);
    end
    checks++;
    if (bcnt !== 1 || bcyc !== exp_done + 1) begin
      errors++;
      $display("FAIL %s busy_fall: falls=%0d cyc=%0d, required falls=1 cyc=%0d",
               name, bcnt, bcyc, exp_done + 1);
    end
    checks++;
    if (err_v[sel] !== 2'(exp_err)) begin
      errors++;
      $display("FAIL %s err: got %b, required %b", name, err_v[sel], 2'(exp_err));
    end
    if (sel == 1) begin
      for (int j = 0; j + 1 < nw; j++) begin
        checks++;
        if (xq[j + 1] - xq[j] < 2) begin
          errors++;
          $display("FAIL %s sym_rate: transfers %0d and %0d at cycles %0d,%0d, required gap>=2",
                   name, j, j + 1, xq[j], xq[j + 1]);
        end
      end
    end
    for (int a = 0; a < FO; a++) begin
      checks++;
      if (mem_dut[sel][a] !== mem_ref[sel][a]) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %h, required %h", name, a, mem_dut[sel][a], mem_ref[sel][a]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rdy_v !== 2'b00 || we_v !== 2'b00 || busy_v !== 2'b00 || done_v !== 2'b00 ||
        err_v[0] !== 2'b00 || err_v[1] !== 2'b00 ||
        bus0.coef_addr_o !== '0 || bus0.coef_data_o !== '0 ||
        bus1.coef_addr_o !== '0 || bus1.coef_data_o !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b we=%b busy=%b done=%b err0=%b err1=%b addr0=%0d data0=%h, required all zero",
               rdy_v, we_v, busy_v, done_v, err_v[0], err_v[1], bus0.coef_addr_o, bus0.coef_data_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_no_consume();
    wq.delete();
    val_d = 2'b11; data_d[0] = 16'h5A5A; data_d[1] = 16'hA5A5; last_d = 2'b11;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      checks++;
      if (rdy_v !== 2'b00 || busy_v !== 2'b00) begin
        errors++;
        $display("FAIL idle_rdy: rdy=%b busy=%b, required rdy=00 busy=00", rdy_v, busy_v);
      end
    end
    val_d = 2'b00; last_d = 2'b00;
    @(negedge clk);
    checks++;
    if (wq.size() !== 0) begin
      errors++;
      $display("FAIL idle_writes: got %0d writes, required 0", wq.size());
    end
  endtask

  task automatic test_reset_midload();
    int got;
    wq.delete();
    @(negedge clk); start_d[0] = 1'b1;
    @(negedge clk); start_d[0] = 1'b0;
    words.delete();
    for (int j = 0; j < 3; j++) begin
      words.push_back(int'($urandom_range(16'hFFFF)));
      val_d[0] = 1'b1; data_d[0] = CW'(words[j]); last_d[0] = 1'b0;
      @(negedge clk);
    end
    val_d[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus0.coef_we_o !== 1'b0 || bus0.s_rdy_o !== 1'b0 || bus0.busy_o !== 1'b0 ||
        bus0.done_o !== 1'b0 || bus0.err_o !== 2'b00 ||
        bus0.coef_addr_o !== '0 || bus0.coef_data_o !== '0) begin
      errors++;
      $display("FAIL reset_midload_outputs: we=%b rdy=%b busy=%b addr=%0d data=%h, required all zero",
               bus0.coef_we_o, bus0.s_rdy_o, bus0.busy_o, bus0.coef_addr_o, bus0.coef_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 3; j++) mem_ref[0][j] = CW'(words[j]);
    got = 0;
    foreach (wq[j]) if (wq[j].sel == 0) got++;
    checks++;
    if (got !== 3) begin
      errors++;
      $display("FAIL reset_midload_writes: got %0d writes, required 3", got);
    end
  endtask

  initial begin
    data_d[0] = '0;
    data_d[1] = '0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < FO; a++) begin
        mem_ref[s][a] = '0;
        mem_dut[s][a] = '0;
      end
    test_reset();
    test_idle_no_consume();
    run_frame(0, 8, 16'h0010, 0, 1'b0, "nominal");
    run_frame(1, 4, 16'h000A, 0, 1'b0, "symmetric");
    run_frame(0, 5, -1, 0, 1'b0, "short");
    run_frame(0, 11, -1, 0, 1'b0, "long");
    run_frame(0, 8, -1, 50, 1'b1, "gaps");
    run_frame(1, 4, -1, 50, 1'b1, "sym_gaps");
    run_frame(1, 2, -1, 30, 1'b0, "sym_short");
    run_frame(1, 6, -1, 30, 1'b0, "sym_long");
    test_reset_midload();
    run_frame(0, 8, -1, 0, 1'b0, "after_reset");
    run_frame(0, 8, -1, 0, 1'b0, "back_to_back");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire

// File: doc/fir_coef_loader.md
# fir_coef_loader

Coefficient-stream loader that drives the coefficient write bus of the FIR resampler (`coef_we_i`/`coef_addr_i`/`coef_data_i`, instantiated with `USE_COEF_WRITE = 1`). It accepts a framed valid/ready stream of coefficient words, assigns sequential addresses, and optionally mirrors a half-length symmetric set into the full table. It checks frame length, reports short and long frames, and signals completion so that control logic can release the filter.

## Interface
- `FILTER_ORDER`, 256, number of taps in the target coefficient memory; must be even when `SYMMETRIC = 1`.
- `COEF_WIDTH`, 16, coefficient word width.
- `SYMMETRIC`, 0, 0: the frame carries `FILTER_ORDER` words; 1: the frame carries `FILTER_ORDER/2` words, and each word is written to address k and to address `FILTER_ORDER-1-k`.
- `COEF_AWIDTH`, `$clog2(FILTER_ORDER)`, address width (derived).
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  one-cycle request to begin a load; ignored unless IDLE.
- `s_data_i`  in  `COEF_WIDTH`  coefficient word.
- `s_val_i`  in  1  word valid.
- `s_last_i`  in  1  last word of the frame; qualified by `s_val_i`.
- `s_rdy_o`  out  1  loader can accept a word.
- `coef_we_o`  out  1  write strobe to the resampler.
- `coef_addr_o`  out  `COEF_AWIDTH`  write address.
- `coef_data_o`  out  `COEF_WIDTH`  write data.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  2  bit0: short frame; bit1: long frame. Both bits are sticky and cleared on an accepted `start_i`.

## Operation
- N = `SYMMETRIC ? FILTER_ORDER/2 : FILTER_ORDER`. The word counter k is `COEF_AWIDTH` bits wide.
- A word transfers when `s_val_i & s_rdy_o`. No word is consumed while `s_rdy_o` = 0.
- FSM states: IDLE, LOAD, MIRROR, DRAIN, FIN.
- **IDLE:**
  - `s_rdy_o` = 0.
  - `start_i` moves the FSM to LOAD, clears k and clears `err_o`.
- **LOAD:**
  - `s_rdy_o` = 1.
  - On transfer, a write of (addr k, data) is registered.
  - If `SYMMETRIC` = 1, the FSM goes to MIRROR.
  - Otherwise the FSM evaluates the end condition, or increments k and stays in LOAD.
- **MIRROR:**
  - `s_rdy_o` = 0.
  - Registers a write of (addr `FILTER_ORDER-1-k`, same data).
  - Then evaluates the end condition, or increments k and returns to LOAD.
- **End condition** (evaluated for the word at index k):
  - k = N-1 and `s_last_i` = 1: go to FIN.
  - k = N-1 and `s_last_i` = 0: set `err_o[1]`, go to DRAIN.
  - k < N-1 and `s_last_i` = 1: set `err_o[0]`, go to FIN. Addresses not written keep their old contents.
- **DRAIN:**
  - `s_rdy_o` = 1.
  - Accepted words are discarded and produce no writes.
  - A transfer with `s_last_i` = 1 moves the FSM to FIN.
- **FIN:**
  - `done_o` = 1 for exactly this cycle, then the FSM returns to IDLE.
  - FIN is always entered after the last `coef_we_o` pulse has been issued.
- `coef_addr_o`/`coef_data_o` hold their last value when `coef_we_o` = 0.
- `start_i` is ignored outside IDLE. `start_i` in the FIN cycle is also ignored.
- Reset in mid-load:
  - Returns the FSM to IDLE on the next edge.
  - Any pending write is dropped.
  - Memory contents are left as partially loaded.

## Timing
- Reset values: `s_rdy_o` = 0, `coef_we_o` = 0, `coef_addr_o` = 0, `coef_data_o` = 0, `busy_o` = 0, `done_o` = 0, `err_o` = 0. State is IDLE and k = 0.
- `start_i` at cycle t: LOAD and `s_rdy_o` = 1 from t+1.
- Transfer at cycle t: `coef_we_o` = 1 at t+1 with addr k. All write outputs are registered.
- `SYMMETRIC` = 1:
  - Mirror write at t+2.
  - `s_rdy_o` = 0 at t+1, so the peak rate is 1 word per 2 cycles.
- `SYMMETRIC` = 0: peak rate is 1 word per cycle, with back-to-back `coef_we_o`.
- `done_o`:
  - Asserted exactly one cycle after the final `coef_we_o` pulse.
  - For DRAIN exit, asserted one cycle after the terminating transfer.
  - `busy_o` drops the cycle after `done_o`.
- Stalls (`s_val_i` = 0) in LOAD or DRAIN hold state and k indefinitely.

## Test plan
- **Nominal load.** `FILTER_ORDER` = 8, `SYMMETRIC` = 0, words 0x0010..0x0017 back-to-back, last on the 8th word → 8 consecutive `coef_we_o` pulses at addr 0..7 with matching data; `done_o` one cycle after the addr-7 write; `err_o` = 0.
- **Symmetric mirroring.** `SYMMETRIC` = 1, `FILTER_ORDER` = 8, words 0xA,0xB,0xC,0xD with last on 0xD → writes (0,A),(7,A),(1,B),(6,B),(2,C),(5,C),(3,D),(4,D); `s_rdy_o` toggles 1/0; `done_o` once.
- **Short frame.** `SYMMETRIC` = 0, 5 words with last on the 5th → writes at addr 0..4 only; `err_o` = 01; `done_o` pulses; the next `start_i` clears `err_o` to 00.
- **Long frame.** `SYMMETRIC` = 0, 11 words with last on the 11th → writes at addr 0..7 only; words 9..11 consumed without writes; `err_o` = 10; `done_o` one cycle after the 11th transfer.
- **Backpressure and random `s_val_i` gaps.** 50% random gaps and a `start_i` pulse during LOAD → `start_i` ignored; address sequence unbroken; `s_rdy_o` = 0 in IDLE with `s_val_i` = 1 (no consumption).
- **Reset mid-load.** `rst_i` asserted after the 3rd transfer → no `coef_we_o` from the next cycle; all outputs at reset values; a fresh load afterwards completes normally from addr 0.
